// File: rtl/nn_pkg.sv
// Shared definitions for the activation stages: FSM state encoding, FIFO timing
// constant and the scalar leaky-ReLU transfer function.
package nn_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, DONE} state_e;

  localparam int RD_LATENCY = 1;

  // 32-bit working width covers any NBits we instantiate; callers sign-extend in and truncate out.
  function automatic logic signed [31:0] leaky_relu(logic signed [31:0] x, int shift, int clamp);
    if (x < 0) return x >>> shift;
    else if (x > clamp) return clamp;
    else return x;
  endfunction

endpackage

// File: rtl/v_leaky_relu.sv
// Chunked saturating leaky-ReLU stage: pulls a vector from the upstream FIFO
// WorkingRegs lanes at a time, activates each lane and pushes it downstream.
module v_leaky_relu
  import nn_pkg::*;
#(
  parameter int InVecLength = 11,
  parameter int WorkingRegs = 11,
  parameter int NBits       = 12,
  parameter int LeakShift   = 3,
  parameter int ClampMax    = 2047
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  in_data_ready,
  input  logic [WorkingRegs-1:0][NBits-1:0]     in_data,
  output logic                                  req_chunk_in,
  output logic [WorkingRegs-1:0][NBits-1:0]     write_out_data,
  output logic                                  req_chunk_out,
  output logic                                  out_vector_valid,
  output logic                                  module_ready
);

  localparam int NCHUNK = InVecLength / WorkingRegs;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((InVecLength % WorkingRegs) != 0 || InVecLength < WorkingRegs) begin : g_bad_len
    $error("InVecLength must be a non-zero multiple of WorkingRegs");
  end
  if (LeakShift < 0 || LeakShift > NBits - 1) begin : g_bad_shift
    $error("LeakShift out of range");
  end
  // LOAD samples rd_data exactly one cycle after FETCH issues rd_en.
  if (RD_LATENCY != 1) begin : g_bad_lat
    $error("FSM assumes a FIFO read latency of one cycle");
  end

  logic [WorkingRegs-1:0][NBits-1:0] lane_y;

  for (genvar i = 0; i < WorkingRegs; i++) begin : g_lane
    logic signed [NBits-1:0] xi;
    assign xi        = in_data[i];
    assign lane_y[i] = NBits'(leaky_relu(32'(xi), LeakShift, ClampMax));
  end

  state_e                            state_q, state_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic [WorkingRegs-1:0][NBits-1:0] wr_q, wr_d;
  logic                              rin_q, rin_d;
  logic                              rout_q, rout_d;
  logic                              ovv_q, ovv_d;
  logic                              rdy_q, rdy_d;

  // Outputs are computed for the state being entered so they register in step with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rin_d   = 1'b0;
    rout_d  = 1'b0;
    ovv_d   = 1'b0;
    rdy_d   = rdy_q;
    case (state_q)
      IDLE: if (in_data_ready) begin
        state_d = FETCH;
        rin_d   = 1'b1;
        rdy_d   = 1'b0;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        wr_d    = lane_y;
        rout_d  = 1'b1;
        state_d = WRITE;
      end
      WRITE: if (cnt_q == LAST) begin
        ovv_d   = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        rin_d   = 1'b1;
        state_d = FETCH;
      end
      DONE: begin
        cnt_d   = '0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rin_q   <= 1'b0;
      rout_q  <= 1'b0;
      ovv_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rin_q   <= rin_d;
      rout_q  <= rout_d;
      ovv_q   <= ovv_d;
      rdy_q   <= rdy_d;
    end
  end

  assign req_chunk_in     = rin_q;
  assign req_chunk_out    = rout_q;
  assign write_out_data   = wr_q;
  assign out_vector_valid = ovv_q;
  assign module_ready     = rdy_q;

endmodule
